nor_bank: RTL and testbench

//   Parametrised bank of CH multi-input NOR gates for the FPGA build of the

---
 rtl/nor_bank_if.sv | 15 +
 rtl/nor_bank.sv | 107 ++++++++++
 tb/tb_nor_bank.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nor_bank_if.sv
// Bus bundle for nor_bank: gate inputs and step enable in, gate outputs and
// settle status out.
interface nor_bank_if #(
    parameter int CH    = 8,
    parameter int FANIN = 2
);
    logic [CH*FANIN-1:0] a;
    logic                en;
    logic [CH-1:0]       y;
    logic                chg;
    logic                stable;

    modport master (output a, en, input  y, chg, stable);
    modport slave  (input  a, en, output y, chg, stable);
endinterface

// File: rtl/nor_bank.sv
// Bank of CH multi-input NOR gates with two-phase timing (sample on negedge,
// update on posedge), configurable latency, step hold and a settle detector.
module nor_bank_lane #(
    parameter int FANIN   = 2,
    parameter int LATENCY = 1,
    parameter bit IV_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [FANIN-1:0] a,
    output logic             y,
    output logic             y_nxt
);
    logic               smp;
    logic [LATENCY:1]   stg;
    logic [LATENCY:1]   stg_nxt;

    always_ff @(negedge clk or posedge rst) begin
        if (rst)     smp <= IV_BIT;
        else if (en) smp <= ~|a;
    end

    always_comb begin
        stg_nxt    = stg;
        stg_nxt[1] = smp;
        for (int k = 2; k <= LATENCY; k++) stg_nxt[k] = stg[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     stg <= {LATENCY{IV_BIT}};
        else if (en) stg <= stg_nxt;
    end

    assign y     = stg[LATENCY];
    // Value y takes at the coming posedge if enabled; feeds change detection.
    assign y_nxt = stg_nxt[LATENCY];
endmodule

module nor_bank #(
    parameter int            CH         = 8,
    parameter int            FANIN      = 2,
    parameter int            LATENCY    = 1,
    parameter logic [CH-1:0] IV         = '0,
    parameter int            STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    nor_bank_if.slave  bus
);
    if (CH < 1 || CH > 64)                  begin : g_bad_ch  $error("nor_bank: CH out of range");         end
    if (FANIN < 1 || FANIN > 8)             begin : g_bad_fi  $error("nor_bank: FANIN out of range");      end
    if (LATENCY < 1 || LATENCY > 4)         begin : g_bad_lat $error("nor_bank: LATENCY out of range");    end
    if (STABLE_CYC < 1 || STABLE_CYC > 255) begin : g_bad_sc  $error("nor_bank: STABLE_CYC out of range"); end

    localparam logic [7:0] SC = 8'(STABLE_CYC);

    logic [CH-1:0] y;
    logic [CH-1:0] y_nxt;
    logic          changed;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic          chg;
    logic          stable;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        nor_bank_lane #(
            .FANIN   (FANIN),
            .LATENCY (LATENCY),
            .IV_BIT  (IV[i])
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (bus.en),
            .a     (bus.a[i*FANIN +: FANIN]),
            .y     (y[i]),
            .y_nxt (y_nxt[i])
        );
    end

    assign changed = (y_nxt != y);

    // A change always wins over a saturated count.
    always_comb begin
        cnt_nxt = cnt;
        if (changed)        cnt_nxt = '0;
        else if (cnt != SC) cnt_nxt = cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            chg    <= 1'b0;
            stable <= 1'b0;
        end else if (bus.en) begin
            cnt    <= cnt_nxt;
            chg    <= changed;
            stable <= (cnt_nxt == SC);
        end else begin
            chg    <= 1'b0;
        end
    end

    assign bus.y      = y;
    assign bus.chg    = chg;
    assign bus.stable = stable;
endmodule

// File: tb/tb_nor_bank.sv
// Directed bench for nor_bank: reset, latency, hold, oscillation and
// mid-cycle reset scenarios across several parameterisations.
module tb_nor_bank;
    logic clk = 1'b0;
    logic rst;
    logic brk;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nor_bank_if #(.CH(4), .FANIN(2)) if1 ();
    nor_bank_if #(.CH(4), .FANIN(2)) if3 ();
    nor_bank_if #(.CH(2), .FANIN(1)) if5 ();
    nor_bank_if #(.CH(4), .FANIN(2)) if6 ();

    nor_bank #(.CH(4), .FANIN(2), .LATENCY(1), .IV(4'b1010), .STABLE_CYC(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    nor_bank #(.CH(4), .FANIN(2), .LATENCY(3), .IV(4'b1010), .STABLE_CYC(4))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    nor_bank #(.CH(2), .FANIN(1), .LATENCY(1), .IV(2'b00), .STABLE_CYC(4))
        u5 (.clk(clk), .rst(rst), .bus(if5));
    nor_bank #(.CH(4), .FANIN(2), .LATENCY(4), .IV(4'b1010), .STABLE_CYC(4))
        u6 (.clk(clk), .rst(rst), .bus(if6));

    // Gate0 of u5 feeds back on itself until brk opens the loop.
    assign if5.a = {1'b1, brk ? 1'b0 : if5.y[0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; brk = 1'b0;
        if1.en = 1'b1; if3.en = 1'b1; if5.en = 1'b1; if6.en = 1'b1;
        if1.a = '0; if3.a = '0; if6.a = '0;

        tick();                                   // t=6
        chk("rst_y",      32'(if1.y), 32'hA);
        chk("rst_chg",    32'(if1.chg), 0);
        chk("rst_stable", 32'(if1.stable), 0);
        chk("rst_y6",     32'(if6.y), 32'hA);
        rst = 1'b0;

        tick();                                   // t=16
        chk("first_y",    32'(if1.y), 32'hF);
        chk("first_chg",  32'(if1.chg), 1);
        chk("first_st",   32'(if1.stable), 0);
        chk("osc_y_a",    32'(if5.y), 32'h1);
        chk("osc_chg_a",  32'(if5.chg), 1);
        tick();                                   // t=26
        chk("osc_y_b",    32'(if5.y), 32'h0);
        tick();                                   // t=36
        chk("st_cnt2",    32'(if1.stable), 0);
        tick();                                   // t=46
        chk("st_cnt3",    32'(if1.stable), 0);
        tick();                                   // t=56
        chk("st_cnt4",    32'(if1.stable), 1);
        chk("st_chg0",    32'(if1.chg), 0);
        chk("lat3_init",  32'(if3.y), 32'hF);
        chk("osc_y_c",    32'(if5.y), 32'h1);
        chk("osc_chg_c",  32'(if5.chg), 1);
        chk("osc_st_c",   32'(if5.stable), 0);
        if1.a = 8'h01; if3.a = 8'h01; brk = 1'b1;

        tick();                                   // t=66
        chk("lat1_y",     32'(if1.y), 32'hE);
        chk("lat1_chg",   32'(if1.chg), 1);
        chk("st_drop",    32'(if1.stable), 0);
        chk("lat3_y_p1",  32'(if3.y), 32'hF);
        if1.en = 1'b0; if1.a = '1;
        tick();                                   // t=76
        chk("hold_y_a",   32'(if1.y), 32'hE);
        chk("hold_chg",   32'(if1.chg), 0);
        chk("lat3_y_p2",  32'(if3.y), 32'hF);
        tick();                                   // t=86
        chk("lat3_y_p3",  32'(if3.y), 32'hE);
        chk("brk_st_a",   32'(if5.stable), 0);
        tick();                                   // t=96
        chk("brk_st_b",   32'(if5.stable), 1);
        chk("brk_chg",    32'(if5.chg), 0);
        tick();                                   // t=106
        tick();                                   // t=116
        chk("hold_y_b",   32'(if1.y), 32'hE);
        chk("hold_st",    32'(if1.stable), 0);
        if1.en = 1'b1;
        tick();                                   // t=126
        chk("resume_y",   32'(if1.y), 32'h0);
        chk("resume_chg", 32'(if1.chg), 1);
        tick();                                   // t=136
        chk("resume_c0",  32'(if1.chg), 0);
        tick();                                   // t=146
        if1.en = 1'b0;
        tick(); tick(); tick();                   // t=176
        chk("cnt_hold",   32'(if1.stable), 0);
        if1.en = 1'b1;
        tick();                                   // t=186
        chk("cnt_res3",   32'(if1.stable), 0);
        tick();                                   // t=196
        chk("cnt_res4",   32'(if1.stable), 1);
        chk("full_y6",    32'(if6.y), 32'hF);

        #2 rst = 1'b1;                            // mid-cycle, t=198
        #1;
        chk("mid_y",      32'(if1.y), 32'hA);
        chk("mid_chg",    32'(if1.chg), 0);
        chk("mid_stable", 32'(if1.stable), 0);
        chk("mid_y3",     32'(if3.y), 32'hA);
        chk("mid_y6",     32'(if6.y), 32'hA);
        if6.a = '1;
        #4 rst = 1'b0;                            // t=203
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("no_stale_%0d", k), 32'(if6.y), 32'hA);
        end
        tick();                                   // t=246
        chk("post_rst_y6", 32'(if6.y), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
